// File: rtl/ins_fetch.sv
// Instruction fetch stage: reads one word from wait-stated SRAM per PC address and
// hands it to IF-ID. Optional one-entry fetch cache enabled by defining FETCH_CACHE_EN.
module ins_fetch #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INS     = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       insAddr_i,
  input  logic              flush_i,
  input  logic [31:0]       sramData_i,
  output logic [ADDR_W-1:0] sramAddr_o,
  output logic              sramCe_n_o,
  output logic              sramOe_n_o,
  output logic [31:0]       ins_o,
  output logic [31:0]       pcPlusOne_o,
  output logic              insValid_o,
  output logic              stallReq_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              strobe_n_q, strobe_n_d;
  logic [31:0]       ins_q, ins_d;
  logic [31:0]       pc_plus_one_q, pc_plus_one_d;
  logic              valid_q, valid_d;
  logic              out_of_range;
  logic              cache_hit;
  logic [31:0]       cache_data;
  logic              done_flush;

`ifdef FETCH_CACHE_EN
  logic        tag_valid_q, tag_valid_d;
  logic [31:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;

  assign cache_hit  = tag_valid_q && (insAddr_i == tag_q);
  assign cache_data = data_q;
`else
  assign cache_hit  = 1'b0;
  assign cache_data = NOP_INS;
`endif

  assign out_of_range = (insAddr_i >> ADDR_W) != 32'd0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    sram_addr_d   = sram_addr_q;
    strobe_n_d    = strobe_n_q;
    ins_d         = ins_q;
    pc_plus_one_d = pc_plus_one_q;
    valid_d       = 1'b0;
`ifdef FETCH_CACHE_EN
    tag_valid_d   = tag_valid_q;
    tag_d         = tag_q;
    data_d        = data_q;
`endif
    unique case (state_q)
      StIdle: begin
        addr_d = insAddr_i;
        if (out_of_range) begin
          state_d       = StDone;
          ins_d         = NOP_INS;
          pc_plus_one_d = insAddr_i + 32'd1;
          valid_d       = 1'b1;
        end else if (cache_hit) begin
          state_d       = StDone;
          ins_d         = cache_data;
          pc_plus_one_d = insAddr_i + 32'd1;
          valid_d       = 1'b1;
        end else begin
          state_d     = StAccess;
          sram_addr_d = insAddr_i[ADDR_W-1:0];
          strobe_n_d  = 1'b0;
          cnt_d       = CntInit;
        end
      end
      StAccess: begin
        if (flush_i) begin
          // Jump resolved in ID: abandon the read, PC is already redirected.
          state_d    = StIdle;
          strobe_n_d = 1'b1;
          cnt_d      = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d       = StDone;
          strobe_n_d    = 1'b1;
          ins_d         = sramData_i;
          pc_plus_one_d = addr_q + 32'd1;
          valid_d       = 1'b1;
`ifdef FETCH_CACHE_EN
          tag_valid_d   = 1'b1;
          tag_d         = addr_q;
          data_d        = sramData_i;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        ins_d   = NOP_INS;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      addr_q        <= 32'd0;
      sram_addr_q   <= '0;
      strobe_n_q    <= 1'b1;
      ins_q         <= NOP_INS;
      pc_plus_one_q <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      sram_addr_q   <= sram_addr_d;
      strobe_n_q    <= strobe_n_d;
      ins_q         <= ins_d;
      pc_plus_one_q <= pc_plus_one_d;
      valid_q       <= valid_d;
    end
  end

`ifdef FETCH_CACHE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid_q <= 1'b0;
      tag_q       <= 32'd0;
      data_q      <= 32'd0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end
`endif

  // A flush arriving while the result is on the bus kills it in the same cycle.
  assign done_flush  = (state_q == StDone) && flush_i;
  assign insValid_o  = valid_q && !done_flush;
  assign ins_o       = done_flush ? NOP_INS : ins_q;
  assign pcPlusOne_o = pc_plus_one_q;
  assign sramAddr_o  = sram_addr_q;
  assign sramCe_n_o  = strobe_n_q;
  assign sramOe_n_o  = strobe_n_q;
  assign stallReq_o  = (state_q != StDone);

endmodule
